// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: three masters share one classic single-beat slave bus,
// with a per-transfer watchdog and one idle turnaround cycle after every grant.
module wb_rr_arbiter #(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_cyc_i,
  input  logic [AW-1:0] m0_adr_i,
  input  logic [DW-1:0] m0_dat_i,
  input  logic          m0_we_i,
  output logic [DW-1:0] m0_dat_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  input  logic          m1_cyc_i,
  input  logic [AW-1:0] m1_adr_i,
  input  logic [DW-1:0] m1_dat_i,
  input  logic          m1_we_i,
  output logic [DW-1:0] m1_dat_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  input  logic          m2_cyc_i,
  input  logic [AW-1:0] m2_adr_i,
  input  logic [DW-1:0] m2_dat_i,
  input  logic          m2_we_i,
  output logic [DW-1:0] m2_dat_o,
  output logic          m2_ack_o,
  output logic          m2_err_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  output logic [AW-1:0] s_adr_o,
  output logic [DW-1:0] s_dat_o,
  input  logic [DW-1:0] s_dat_i,
  input  logic          s_ack_i,
  output logic [1:0]    grant_o,
  output logic          timeout_o
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, BUS, RELEASE} state_t;

  state_t        r_state, w_nextState;
  logic [1:0]    r_grant, w_nextGrant;
  logic [1:0]    r_ptr, w_nextPtr;
  logic [CW-1:0] r_count, w_nextCount;

  logic [2:0]    w_req;
  logic [1:0]    w_winner;
  logic          w_gCyc, w_gWe;
  logic [AW-1:0] w_gAdr;
  logic [DW-1:0] w_gDat;
  logic          w_bus, w_timeout, w_exit;
  logic [2:0]    w_sel;

  assign w_req = {m2_cyc_i, m1_cyc_i, m0_cyc_i};

  // Search order starts at the rotating pointer and wraps through the other two masters.
  always_comb begin
    w_winner = 2'd3;
    case (r_ptr)
      2'd0: if (w_req[0]) w_winner = 2'd0; else if (w_req[1]) w_winner = 2'd1; else if (w_req[2]) w_winner = 2'd2;
      2'd1: if (w_req[1]) w_winner = 2'd1; else if (w_req[2]) w_winner = 2'd2; else if (w_req[0]) w_winner = 2'd0;
      default: if (w_req[2]) w_winner = 2'd2; else if (w_req[0]) w_winner = 2'd0; else if (w_req[1]) w_winner = 2'd1;
    endcase
  end

  always_comb begin
    w_gCyc = 1'b0;
    w_gWe  = 1'b0;
    w_gAdr = '0;
    w_gDat = '0;
    case (r_grant)
      2'd0: begin w_gCyc = m0_cyc_i; w_gWe = m0_we_i; w_gAdr = m0_adr_i; w_gDat = m0_dat_i; end
      2'd1: begin w_gCyc = m1_cyc_i; w_gWe = m1_we_i; w_gAdr = m1_adr_i; w_gDat = m1_dat_i; end
      2'd2: begin w_gCyc = m2_cyc_i; w_gWe = m2_we_i; w_gAdr = m2_adr_i; w_gDat = m2_dat_i; end
      default: ;
    endcase
  end

  // Outputs are gated by rst_n so a transfer cut off by reset never reports ack or err.
  assign w_bus     = rst_n && (r_state == BUS);
  assign w_timeout = w_bus && (TIMEOUT != 0) && (r_count == TIMEOUT_CNT) && !s_ack_i && w_gCyc;
  assign w_exit    = s_ack_i || !w_gCyc || w_timeout;

  always_comb begin
    w_nextState = r_state;
    w_nextGrant = r_grant;
    w_nextPtr   = r_ptr;
    w_nextCount = r_count;
    case (r_state)
      IDLE: begin
        if (|w_req) begin
          w_nextState = BUS;
          w_nextGrant = w_winner;
          w_nextCount = CW'(1);
        end
      end
      BUS: begin
        if (w_exit) begin
          w_nextState = RELEASE;
          w_nextGrant = 2'd3;
          w_nextPtr   = (r_grant == 2'd2) ? 2'd0 : r_grant + 2'd1;
          w_nextCount = '0;
        end else begin
          w_nextCount = r_count + CW'(1);
        end
      end
      RELEASE: begin
        w_nextState = IDLE;
        w_nextGrant = 2'd3;
      end
      default: begin
        w_nextState = IDLE;
        w_nextGrant = 2'd3;
        w_nextCount = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_grant <= 2'd3;
      r_ptr   <= 2'd0;
      r_count <= '0;
    end else begin
      r_state <= w_nextState;
      r_grant <= w_nextGrant;
      r_ptr   <= w_nextPtr;
      r_count <= w_nextCount;
    end
  end

  assign w_sel[0] = w_bus && (r_grant == 2'd0);
  assign w_sel[1] = w_bus && (r_grant == 2'd1);
  assign w_sel[2] = w_bus && (r_grant == 2'd2);

  assign s_cyc_o   = w_bus;
  assign s_stb_o   = w_bus;
  assign s_we_o    = w_bus && w_gWe;
  assign s_adr_o   = w_bus ? w_gAdr : '0;
  assign s_dat_o   = w_bus ? w_gDat : '0;
  assign grant_o   = r_grant;
  assign timeout_o = w_timeout;

  assign m0_ack_o = w_sel[0] && s_ack_i;
  assign m1_ack_o = w_sel[1] && s_ack_i;
  assign m2_ack_o = w_sel[2] && s_ack_i;
  assign m0_err_o = w_sel[0] && w_timeout;
  assign m1_err_o = w_sel[1] && w_timeout;
  assign m2_err_o = w_sel[2] && w_timeout;
  assign m0_dat_o = w_sel[0] ? s_dat_i : '0;
  assign m1_dat_o = w_sel[1] ? s_dat_i : '0;
  assign m2_dat_o = w_sel[2] ? s_dat_i : '0;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: grant order, zero-wait throughput, watchdog, abort and reset.
// Every ack/err seen on the master side is matched against a queue of expected completions.
module tb_wb_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  mCyc, mWe;
  logic [31:0] mAdr [3];
  logic [31:0] mDat [3];
  logic [31:0] m0Rd, m1Rd, m2Rd;
  logic        m0Ack, m1Ack, m2Ack, m0Err, m1Err, m2Err;
  logic        sCyc, sStb, sWe, sAck, timeoutPulse;
  logic [31:0] sAdr, sDatOut, sDatIn;
  logic [1:0]  grant;

  int nChecks = 0;
  int nFails  = 0;
  logic [101:0] sbQ [$];

  wb_rr_arbiter #(.DW(32), .AW(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_cyc_i(mCyc[0]), .m0_adr_i(mAdr[0]), .m0_dat_i(mDat[0]), .m0_we_i(mWe[0]),
    .m0_dat_o(m0Rd), .m0_ack_o(m0Ack), .m0_err_o(m0Err),
    .m1_cyc_i(mCyc[1]), .m1_adr_i(mAdr[1]), .m1_dat_i(mDat[1]), .m1_we_i(mWe[1]),
    .m1_dat_o(m1Rd), .m1_ack_o(m1Ack), .m1_err_o(m1Err),
    .m2_cyc_i(mCyc[2]), .m2_adr_i(mAdr[2]), .m2_dat_i(mDat[2]), .m2_we_i(mWe[2]),
    .m2_dat_o(m2Rd), .m2_ack_o(m2Ack), .m2_err_o(m2Err),
    .s_cyc_o(sCyc), .s_stb_o(sStb), .s_we_o(sWe), .s_adr_o(sAdr), .s_dat_o(sDatOut),
    .s_dat_i(sDatIn), .s_ack_i(sAck), .grant_o(grant), .timeout_o(timeoutPulse)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Completion record layout: {ack[2:0], err[2:0], dat2, dat1, dat0}.
  function automatic logic [101:0] mkExp(input logic [1:0] g, input bit isErr, input logic [31:0] d);
    logic [101:0] r;
    r = '0;
    if (isErr) r[96 + int'(g)] = 1'b1;
    else       r[99 + int'(g)] = 1'b1;
    r[int'(g)*32 +: 32] = d;
    return r;
  endfunction

  // Scoreboard side: any ack or err must match the oldest expected completion.
  always @(negedge clk) begin
    logic [101:0] obs, exp;
    obs = {m2Ack, m1Ack, m0Ack, m2Err, m1Err, m0Err, m2Rd, m1Rd, m0Rd};
    if (|obs[101:96]) begin
      exp = (sbQ.size() > 0) ? sbQ.pop_front() : '0;
      checkOutput("completion", obs, exp);
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Called at the start of a BUS cycle for master g; the slave acks at once.
  task automatic applyStimulus(input logic [1:0] g, input logic [31:0] d, input bit drop);
    sAck = 1'b1;
    sDatIn = d;
    sbQ.push_back(mkExp(g, 1'b0, d));
    @(negedge clk);
    checkOutput("busGrant", grant, g);
    checkOutput("busStb", sStb, 1);
    checkOutput("busAdr", sAdr, mAdr[g]);
    checkOutput("busWe", sWe, mWe[g]);
    checkOutput("busDat", sDatOut, mDat[g]);
    nextCycle();
    sAck = 1'b0;
    sDatIn = '0;
    if (drop) mCyc[g] = 1'b0;
    @(negedge clk);
    checkOutput("releaseGrant", grant, 2'd3);
    checkOutput("releaseStb", sStb, 0);
    nextCycle();
    @(negedge clk);
    checkOutput("idleGrant", grant, 2'd3);
    nextCycle();
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    nextCycle();
    nextCycle();
    @(negedge clk);
    checkOutput("rstGrant", grant, 2'd3);
    checkOutput("rstBus", {sCyc, sStb, sWe, timeoutPulse}, 4'b0);
    checkOutput("rstAdr", sAdr, 0);
    rst_n = 1'b1;
    nextCycle();
  endtask

  initial begin
    rst_n = 1'b0; mCyc = '0; mWe = '0; sAck = 1'b0; sDatIn = '0;
    for (int i = 0; i < 3; i++) begin mAdr[i] = '0; mDat[i] = '0; end

    $display("[TB] single read by m1");
    doReset();
    mCyc[1] = 1'b1; mAdr[1] = 32'h40;
    @(negedge clk);
    checkOutput("t1IdleStb", sStb, 0);
    nextCycle();
    @(negedge clk);
    checkOutput("t1Grant", grant, 2'd1);
    checkOutput("t1Stb", sStb, 1);
    checkOutput("t1Adr", sAdr, 32'h40);
    nextCycle();
    sAck = 1'b1; sDatIn = 32'hDEADBEEF;
    sbQ.push_back(mkExp(2'd1, 1'b0, 32'hDEADBEEF));
    @(negedge clk);
    checkOutput("t1Grant2", grant, 2'd1);
    nextCycle();
    sAck = 1'b0; sDatIn = '0; mCyc[1] = 1'b0;
    @(negedge clk);
    checkOutput("t1RelGrant", grant, 2'd3);
    checkOutput("t1RelStb", sStb, 0);
    nextCycle();

    $display("[TB] m0 and m2 after m1 served");
    mCyc[0] = 1'b1; mAdr[0] = 32'h1000;
    mCyc[2] = 1'b1; mAdr[2] = 32'h2000;
    nextCycle();
    applyStimulus(2'd2, 32'h22220002, 1'b1);
    applyStimulus(2'd0, 32'h00000A0A, 1'b1);
    @(negedge clk);
    checkOutput("t3Idle", {grant, sStb}, {2'd3, 1'b0});

    $display("[TB] three simultaneous requests");
    doReset();
    mCyc = 3'b111;
    mAdr[0] = 32'h100; mAdr[1] = 32'h200; mAdr[2] = 32'h300;
    mWe[1] = 1'b1; mDat[1] = 32'hA5A5A5A5;
    nextCycle();
    applyStimulus(2'd0, 32'h11111111, 1'b0);
    applyStimulus(2'd1, 32'h22222222, 1'b1);
    applyStimulus(2'd2, 32'h33333333, 1'b1);
    applyStimulus(2'd0, 32'h44444444, 1'b1);
    mWe[1] = 1'b0;
    @(negedge clk);
    checkOutput("t2Idle", {grant, sStb}, {2'd3, 1'b0});

    $display("[TB] watchdog on m2 write");
    doReset();
    mCyc[2] = 1'b1; mWe[2] = 1'b1; mAdr[2] = 32'h3C; mDat[2] = 32'h12345678;
    nextCycle();
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) nextCycle();
      if (k == 1) mCyc[0] = 1'b1;
      if (k == 8) sbQ.push_back(mkExp(2'd2, 1'b1, 32'h0));
      @(negedge clk);
      checkOutput("t4Grant", grant, 2'd2);
      checkOutput("t4Stb", sStb, 1);
      checkOutput("t4Timeout", timeoutPulse, (k == 8) ? 1 : 0);
      if (k == 1) checkOutput("t4WrDat", {sWe, sDatOut}, {1'b1, 32'h12345678});
    end
    nextCycle();
    mCyc[2] = 1'b0; mWe[2] = 1'b0;
    @(negedge clk);
    checkOutput("t4Release", {grant, sStb, timeoutPulse}, {2'd3, 2'b00});
    nextCycle();
    nextCycle();
    applyStimulus(2'd0, 32'h0BADF00D, 1'b1);

    $display("[TB] abort by m0");
    doReset();
    mCyc[0] = 1'b1; mAdr[0] = 32'h500;
    nextCycle();
    @(negedge clk);
    checkOutput("t5Grant", grant, 2'd0);
    nextCycle();
    mCyc[0] = 1'b0;
    @(negedge clk);
    checkOutput("t5StbHeld", sStb, 1);
    nextCycle();
    @(negedge clk);
    checkOutput("t5Release", {grant, sStb}, {2'd3, 1'b0});
    nextCycle();
    mCyc[0] = 1'b1; mCyc[1] = 1'b1; mAdr[1] = 32'h600;
    nextCycle();
    applyStimulus(2'd1, 32'h55550001, 1'b1);
    applyStimulus(2'd0, 32'h55550000, 1'b1);

    $display("[TB] reset during BUS with ack");
    doReset();
    mCyc[1] = 1'b1; mAdr[1] = 32'h700;
    nextCycle();
    sAck = 1'b1; sDatIn = 32'hCAFEF00D; rst_n = 1'b0;
    @(negedge clk);
    checkOutput("t6BusOff", {sCyc, sStb}, 2'b00);
    checkOutput("t6Rd", m1Rd, 0);
    nextCycle();
    sAck = 1'b0; sDatIn = '0;
    @(negedge clk);
    checkOutput("t6Grant", grant, 2'd3);
    checkOutput("t6Stb", sStb, 0);
    rst_n = 1'b1;
    nextCycle();
    nextCycle();
    applyStimulus(2'd1, 32'hCAFEF00D, 1'b1);

    nextCycle();
    checkOutput("scoreboardEmpty", sbQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
